lzd_norm_sched: RTL and testbench
=================================

# lzd_norm_sched

Sequential leading-zero count and normalize unit shared between two requesters in the Box-Muller AWGN datapath: the logarithm unit (port 0) and the square-root unit (port 1). It grants one request at a time using round-robin arbitration. It scans the captured word one CHUNK-bit slice per cycle using a 2-bit LZD-cell tree, then returns the leading-zero count and the left-normalized word over a valid/ready response handshake.

## Interface
- W, 48, operand width; must be a multiple of CHUNK
- CHUNK, 8, bits examined per SCAN cycle; power of two, at least 2
- LZW, clog2(W+1) = 6, width of the count output
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 or port 1
- req0_data / req1_data  in  W  operand to normalize
- req0_ready / req1_ready  out  1  request accepted on this cycle
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_id  out  1  index of the port being served
- resp_lzc  out  LZW  leading zeros counted from the MSB; equals W when the operand is zero
- resp_norm  out  W  operand shifted left by resp_lzc; zero-filled
- resp_zero  out  1  operand was all zeros

## Operation
- **State machine:** IDLE, SCAN, DONE.
- **Reset values:** state IDLE, rr pointer 0, all outputs 0, internal shift register 0, internal count 0.
- **IDLE, arbitration:**
  - If exactly one valid is high, that port is granted.
  - If both are high, the port selected by the rr pointer is granted (rr=0 selects port 0).
  - reqN_ready is high only in IDLE, and only for the granted port, when that port's valid is high.
- **IDLE, accept:** on a cycle where valid and ready are both high:
  - load the shift register with the operand,
  - clear the count,
  - latch the port into resp_id,
  - set rr to the other port,
  - go to SCAN.
- **SCAN, per cycle:** the lzd_chunk sub-module examines the top CHUNK bits and produces v (any bit set) and z (in-chunk leading zeros).
  - v=1: resp_norm <= shreg << z; resp_lzc <= count + z; resp_zero <= 0; go to DONE.
  - v=0 and this is not the last chunk: shreg <<= CHUNK; count += CHUNK; stay in SCAN.
  - v=0 on the last chunk (W/CHUNK chunks examined): resp_lzc <= W; resp_norm <= 0; resp_zero <= 1; go to DONE.
- **DONE:** resp_valid=1. All resp_* outputs are held stable until resp_ready=1. On the handshake cycle, go to IDLE and resp_valid <= 0.
- **No overlap:** requests are not accepted in SCAN or DONE. Both ready outputs are 0 in those states.
- **Arithmetic:** the count never exceeds W. Use the LZW-bit adder; no saturation logic is needed.
- **Reset mid-operation:** the transaction is dropped and no response is produced. The rr pointer returns to 0.

## Timing
- **Latency:** let the accept edge be E0, and let k be the 0-based index of the first nonzero chunk. resp_valid rises after edge E0+k+1.
- An all-zero operand gives resp_valid after E0+W/CHUNK. With the defaults that is 6 edges, the same as k=5.
- **Throughput:** the earliest next accept is the cycle after the resp handshake edge. The minimum period is k+3 cycles.
- All outputs are registered except reqN_ready, which is combinational from state, rr and the valid inputs.
- resp_ready has no effect outside DONE.

## Structure
- **Package lzd_norm_pkg:**
  - the state enum (IDLE, SCAN, DONE),
  - default W and CHUNK constants,
  - the LZW derivation function.
- **Sub-module lzd_chunk:** combinational, CHUNK-bit. It is built as a log2(CHUNK)-level tree of 2-bit LZD cells producing (p, v) pairs, and outputs v and a log2(CHUNK)-bit z.
  - For an all-zero chunk, z is don't-care.
  - lzd_chunk is the only instance.

## Test plan
1. **Reset:** assert rst_n=0 with both valids high. All outputs must be 0. Release reset: req0_ready=1 and req1_ready=0 on the first IDLE cycle.
2. **Port 0, MSB set:** req0_data=48'h8000_0000_0000 (k=0). Required response after E0+1: resp_lzc=0, resp_norm=48'h8000_0000_0000, resp_zero=0, resp_id=0.
3. **Port 1, LSB set:** req1_data=48'h0000_0000_0001 (k=5). Required response after E0+6: resp_lzc=47, resp_norm=48'h8000_0000_0000, resp_id=1. Also check data 48'h0000_00F0_0000 (k=3): resp_lzc=24, resp_norm=48'hF000_0000_0000.
4. **Zero operand:** data=0. Required response after E0+6: resp_zero=1, resp_lzc=48, resp_norm=0.
5. **Fairness:** both valids held high with resp_ready=1. Grants must alternate 0,1,0,1 and resp_id must follow the same sequence. Then drop req1_valid: port 0 must be granted on consecutive transactions.
6. **Backpressure and reset mid-SCAN:**
   - Hold resp_ready=0 for 5 cycles in DONE: resp_* must stay unchanged and both ready outputs must stay 0.
   - Pulse rst_n low during SCAN of a k=5 operand: resp_valid must never assert, the next accept must go to port 0, and the result must be correct.

Source files
------------

// File: rtl/lzd_norm_sched_pkg.sv
// Shared types and constants for the shared leading-zero-count / normalize unit.
package lzd_norm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int W_DEF     = 48;
    localparam int CHUNK_DEF = 8;

    function automatic int lzw_f(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lzd_norm_sched_if.sv
// Request/response bundle between the two requesters and the normalize unit.
interface lzd_norm_sched_if
    import lzd_norm_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int LZW = lzw_f(W)
);
    logic           req0_valid;
    logic           req0_ready;
    logic [W-1:0]   req0_data;
    logic           req1_valid;
    logic           req1_ready;
    logic [W-1:0]   req1_data;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_id;
    logic [LZW-1:0] resp_lzc;
    logic [W-1:0]   resp_norm;
    logic           resp_zero;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_lzc, resp_norm, resp_zero
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_lzc, resp_norm, resp_zero
    );
endinterface

// File: rtl/lzd_norm_sched_chunk.sv
// Combinational leading-zero detector for one CHUNK-bit slice, built as a tree of 2-bit LZD cells.
module lzd_chunk #(
    parameter int CHUNK = 8,
    parameter int ZW    = $clog2(CHUNK)
) (
    input  logic [CHUNK-1:0] data_i,
    output logic             v_o,
    output logic [ZW-1:0]    z_o
);

    // Level 0 holds the raw bits MSB-first; each higher level merges pairs (upper, lower).
    for (genvar l = 0; l <= ZW; l++) begin : g_lvl
        localparam int N = CHUNK >> l;
        logic [N-1:0]         v;
        logic [N-1:0][ZW-1:0] p;

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign v[i] = data_i[CHUNK-1-i];
                assign p[i] = '0;
            end
        end else begin : g_node
            for (genvar i = 0; i < N; i++) begin : g_cell
                assign v[i] = g_lvl[l-1].v[2*i] | g_lvl[l-1].v[2*i+1];
                assign p[i] = g_lvl[l-1].v[2*i] ? g_lvl[l-1].p[2*i]
                                                : (g_lvl[l-1].p[2*i+1] | ZW'(1 << (l-1)));
            end
        end
    end

    assign v_o = g_lvl[ZW].v[0];
    assign z_o = g_lvl[ZW].p[0];

endmodule

// File: rtl/lzd_norm_sched.sv
// Round-robin shared LZC/normalize unit: scans one chunk per cycle, answers over valid/ready.
//   state   | meaning
//   IDLE    | arbitrate and accept one request
//   SCAN    | examine top chunk of shreg, shift on all-zero chunk
//   DONE    | hold response until resp_ready
module lzd_norm_sched
    import lzd_norm_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CHUNK = CHUNK_DEF,
    parameter int LZW   = lzw_f(W)
) (
    input  logic clk,
    input  logic rst_n,
    lzd_norm_sched_if.slave bus
);

    localparam int              ZW       = $clog2(CHUNK);
    localparam logic [LZW-1:0]  LAST_CNT = LZW'(W - CHUNK);
    localparam logic [LZW-1:0]  W_CNT    = LZW'(W);
    localparam logic [LZW-1:0]  CHUNK_CNT = LZW'(CHUNK);

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [LZW-1:0]  cnt_q, cnt_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_id_q, resp_id_d;
    logic [LZW-1:0]  resp_lzc_q, resp_lzc_d;
    logic [W-1:0]    resp_norm_q, resp_norm_d;
    logic            resp_zero_q, resp_zero_d;

    logic            chunk_v;
    logic [ZW-1:0]   chunk_z;
    logic            gnt1;
    logic            idle;
    logic            accept;

    lzd_chunk #(.CHUNK(CHUNK)) u_chunk (
        .data_i (shreg_q[W-1 -: CHUNK]),
        .v_o    (chunk_v),
        .z_o    (chunk_z)
    );

    // Readies are also gated by rst_n so nothing looks accepted while reset is held.
    assign gnt1   = bus.req1_valid & (~bus.req0_valid | rr_q);
    assign idle   = (state_q == ST_IDLE) & rst_n;
    assign bus.req0_ready = idle & bus.req0_valid & ~gnt1;
    assign bus.req1_ready = idle & gnt1;
    assign accept = bus.req0_ready | bus.req1_ready;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_lzc_d   = resp_lzc_q;
        resp_norm_d  = resp_norm_q;
        resp_zero_d  = resp_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d   = gnt1 ? bus.req1_data : bus.req0_data;
                    cnt_d     = '0;
                    resp_id_d = gnt1;
                    rr_d      = ~gnt1;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (chunk_v) begin
                    resp_norm_d  = shreg_q << chunk_z;
                    resp_lzc_d   = cnt_q + LZW'(chunk_z);
                    resp_zero_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else if (cnt_q == LAST_CNT) begin
                    resp_norm_d  = '0;
                    resp_lzc_d   = W_CNT;
                    resp_zero_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    shreg_d = shreg_q << CHUNK;
                    cnt_d   = cnt_q + CHUNK_CNT;
                end
            end
            ST_DONE: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_lzc_q   <= '0;
            resp_norm_q  <= '0;
            resp_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_lzc_q   <= resp_lzc_d;
            resp_norm_q  <= resp_norm_d;
            resp_zero_q  <= resp_zero_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_lzc   = resp_lzc_q;
    assign bus.resp_norm  = resp_norm_q;
    assign bus.resp_zero  = resp_zero_q;

endmodule

// File: tb/tb_lzd_norm_sched.sv
// Randomized self-checking bench for lzd_norm_sched against a behavioural LZC/arbitration model.
module tb_lzd_norm_sched;

    localparam int W     = 48;
    localparam int CHUNK = 8;
    localparam int LZW   = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   rr_m  = 0;

    lzd_norm_sched_if #(.W(W), .LZW(LZW)) bus ();

    lzd_norm_sched #(.W(W), .CHUNK(CHUNK), .LZW(LZW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_lzc(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--)
            if (d[i]) return W - 1 - i;
        return W;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0] >> $urandom_range(0, W);
    endfunction

    // One transaction: present requests, follow it through SCAN and DONE, hold DONE for bp cycles.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [W-1:0] d0, input logic [W-1:0] d1, input int bp);
        int port, lz, lat, n;
        logic [W-1:0] dsel, expn;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_data  = d0;
        bus.req1_data  = d1;
        bus.resp_ready = (bp == 0);
        #1;
        port = (v0 && v1) ? rr_m : (v1 ? 1 : 0);
        chk("req0_ready", bus.req0_ready, (v0 && port == 0));
        chk("req1_ready", bus.req1_ready, (v1 && port == 1));
        @(posedge clk); #1;
        rr_m = 1 - port;
        dsel = (port == 1) ? d1 : d0;
        lz   = ref_lzc(dsel);
        expn = (lz == W) ? '0 : (dsel << lz);
        lat  = ((lz == W) ? (W / CHUNK - 1) : (lz / CHUNK)) + 1;
        bus.req0_data = rand_word();
        bus.req1_data = rand_word();
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            chk("scan_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("resp_id", bus.resp_id, port);
        chk("resp_lzc", bus.resp_lzc, lz);
        chk("resp_norm", bus.resp_norm, expn);
        chk("resp_zero", bus.resp_zero, (lz == W));
        for (int b = 0; b < bp; b++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.resp_valid, 1'b1);
            chk("hold_resp", {bus.resp_id, bus.resp_zero, bus.resp_lzc, bus.resp_norm},
                {port[0], (lz == W), lz[LZW-1:0], expn});
            chk("hold_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", bus.resp_valid, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        logic seen;
        logic v0, v1;
        rst_n          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 48'h8000_0000_0000;
        bus.req1_data  = 48'h0000_0000_0001;
        bus.resp_ready = 1'b0;
        #12;
        chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        chk("rst_resp", {bus.resp_valid, bus.resp_id, bus.resp_zero, bus.resp_lzc, bus.resp_norm}, '0);
        #10 rst_n = 1'b1;
        #1;
        chk("first_idle_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);

        // Both requesting: grants alternate 0,1,0,1 starting from the reset pointer.
        run_txn(1, 1, 48'h8000_0000_0000, 48'h1234_0000_0000, 0);
        run_txn(1, 1, 48'h0000_0001_0000, 48'h0000_0000_0001, 0);
        run_txn(1, 1, 48'h0000_00F0_0000, 48'h0000_0000_0000, 0);
        run_txn(1, 1, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 0);
        run_txn(1, 0, 48'h0000_0000_0080, 48'h0000_0000_0001, 0);
        run_txn(1, 0, 48'h0400_0000_0000, 48'h0000_0000_0001, 0);
        run_txn(1, 1, 48'h0001_0000_0000, 48'h0000_0300_0000, 5);

        // Reset pulse during SCAN of a k=5 operand accepted on port 0.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req0_data  = 48'h0000_0000_0001;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        rr_m = 0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            seen = seen | bus.resp_valid;
        end
        chk("no_resp_after_rst", seen, 1'b0);
        run_txn(1, 1, 48'h0000_0000_0F00, 48'h8000_0000_0000, 0);

        for (int t = 0; t < 40; t++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(v0, v1, rand_word(), rand_word(), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
